rn_mc: RTL and testbench

//  Multi-source request node: successor to the single-source rn.
//  - Arbitrates NUM_SRC local work requests round-robin onto one credit-flow-controlled tx_req channel.
//  - Tracks up to MAX_OUT outstanding transactions by txn_id and routes rx_data responses back to the issuing source.
//  - Sits between the local work generators and the sn / NoC link.

---
 rtl/node_package.sv | 24 ++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/rn_mc.sv | 201 ++++++++++++++++++++
 tb/tb_rn_mc.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/node_package.sv
// Shared widths and bundle types for the request node.
// Imported by rn_mc and its arbiter.
package node_package;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int TXN_ID_W = 2;
    localparam int SRC_W    = 2;
    localparam int CRED_W   = 4;

    typedef struct packed {
        logic [TXN_ID_W-1:0] txn_id;
        logic [SRC_W-1:0]    src;
        logic [ADDR_W-1:0]   addr;
    } ReqType;

    typedef struct packed {
        logic [TXN_ID_W-1:0] txn_id;
        logic [DATA_W-1:0]   payload;
    } DataType;

    typedef logic [CRED_W-1:0] cred_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last winner.
// The pointer only moves when the grant is actually consumed (adv).
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // first requester at or after the pointer wins; pointer moves past it
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        for (int k = 0; k < N; k++) begin
            if (req[(int'(ptr_q) + k) % N] && grant == '0) begin
                grant[(int'(ptr_q) + k) % N] = 1'b1;
                ptr_d = PW'((int'(ptr_q) + k + 1) % N);
            end
        end
        if (!adv) begin
            ptr_d = ptr_q;
        end
    end

    // pointer register, src 0 has priority after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rn_mc.sv
// Multi-source request node: round-robin issue onto a credited tx_req
// channel, txn table routing rx_data responses back to their source.
module rn_mc
    import node_package::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int MAX_OUT    = 4,
    parameter int TX_CREDITS = 2,
    parameter int RX_CREDITS = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_SRC-1:0]           work,
    input  logic [NUM_SRC*ADDR_W-1:0]    work_addr,
    output logic [NUM_SRC-1:0]           work_rdy,
    input  logic                         pre_tx_req,
    output ReqType                       tx_req,
    output logic                         v_tx_req,
    output logic                         pre_rx_data,
    input  DataType                      rx_data,
    input  logic                         v_rx_data,
    output logic [NUM_SRC-1:0]           done,
    output logic [DATA_W-1:0]            done_data,
    output logic [$clog2(MAX_OUT+1)-1:0] n_out,
    output logic                         err
);

    localparam int NW = $clog2(MAX_OUT + 1);

    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [ADDR_W-1:0]  addr_q [NUM_SRC];
    logic [ADDR_W-1:0]  addr_d [NUM_SRC];
    logic [MAX_OUT-1:0] used_q, used_d;
    logic [SRC_W-1:0]   owner_q [MAX_OUT];
    logic [SRC_W-1:0]   owner_d [MAX_OUT];
    cred_t              tx_cred_q, tx_cred_d;
    cred_t              rx_owe_q, rx_owe_d;
    cred_t              rx_sum;
    ReqType             tx_req_q, tx_req_d;
    logic               v_tx_req_q, v_tx_req_d;
    logic               pre_rx_q, pre_rx_d;
    logic [NUM_SRC-1:0] done_q, done_d;
    logic [DATA_W-1:0]  done_data_q, done_data_d;
    logic [NW-1:0]      n_out_q, n_out_d;
    logic               err_q, err_d;

    logic [NUM_SRC-1:0]  grant;
    logic                issue;
    logic                free_ok;
    logic [TXN_ID_W-1:0] free_id;
    logic [SRC_W-1:0]    win_id;
    logic [ADDR_W-1:0]   win_addr;
    logic [MAX_OUT-1:0]  hit;
    logic [SRC_W-1:0]    hit_src;
    logic                rsp_ok;

    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (pending_q),
        .adv   (issue),
        .grant (grant)
    );

    // issue qualification, free-slot pick and response lookup
    always_comb begin
        free_ok = 1'b0;
        free_id = '0;
        for (int i = MAX_OUT - 1; i >= 0; i--) begin
            if (!used_q[i]) begin
                free_ok = 1'b1;
                free_id = TXN_ID_W'(i);
            end
        end
        win_id   = '0;
        win_addr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                win_id   = SRC_W'(i);
                win_addr = addr_q[i];
            end
        end
        hit     = '0;
        hit_src = '0;
        for (int i = 0; i < MAX_OUT; i++) begin
            if (v_rx_data && used_q[i] &&
                rx_data.txn_id == TXN_ID_W'(i)) begin
                hit[i]  = 1'b1;
                hit_src = owner_q[i];
            end
        end
        rsp_ok = |hit;
        issue  = (|pending_q) && (tx_cred_q != '0) && free_ok;
    end

    // next state for pending requests, table, credits and outputs
    always_comb begin
        pending_d = pending_q & ~(issue ? grant : '0);
        addr_d    = addr_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (work[i] && !pending_q[i]) begin
                pending_d[i] = 1'b1;
                addr_d[i]    = work_addr[i*ADDR_W +: ADDR_W];
            end
        end

        used_d  = used_q & ~hit;
        owner_d = owner_q;
        for (int i = 0; i < MAX_OUT; i++) begin
            if (issue && free_id == TXN_ID_W'(i)) begin
                used_d[i]  = 1'b1;
                owner_d[i] = win_id;
            end
        end

        tx_cred_d = tx_cred_q;
        case ({pre_tx_req, issue})
            2'b10: begin
                if (tx_cred_q < cred_t'(TX_CREDITS)) begin
                    tx_cred_d = tx_cred_q + cred_t'(1);
                end
            end
            2'b01:   tx_cred_d = tx_cred_q - cred_t'(1);
            default: tx_cred_d = tx_cred_q;
        endcase

        n_out_d = n_out_q;
        if (issue && !rsp_ok) begin
            n_out_d = n_out_q + NW'(1);
        end else if (rsp_ok && !issue) begin
            n_out_d = n_out_q - NW'(1);
        end

        v_tx_req_d = issue;
        tx_req_d   = '0;
        if (issue) begin
            tx_req_d.txn_id = free_id;
            tx_req_d.src    = win_id;
            tx_req_d.addr   = win_addr;
        end

        done_d      = '0;
        done_data_d = done_data_q;
        if (rsp_ok) begin
            done_data_d = rx_data.payload;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (hit_src == SRC_W'(i)) begin
                    done_d[i] = 1'b1;
                end
            end
        end
        err_d = err_q | (v_rx_data && !rsp_ok);

        rx_sum   = rx_owe_q + cred_t'(v_rx_data);
        pre_rx_d = (rx_sum != '0);
        rx_owe_d = (rx_sum != '0) ? rx_sum - cred_t'(1) : '0;
    end

    // state registers; rx credit owe count preloaded with the initial grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q   <= '0;
            used_q      <= '0;
            for (int i = 0; i < NUM_SRC; i++) addr_q[i] <= '0;
            for (int i = 0; i < MAX_OUT; i++) owner_q[i] <= '0;
            tx_cred_q   <= '0;
            rx_owe_q    <= cred_t'(RX_CREDITS);
            tx_req_q    <= '0;
            v_tx_req_q  <= 1'b0;
            pre_rx_q    <= 1'b0;
            done_q      <= '0;
            done_data_q <= '0;
            n_out_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            used_q      <= used_d;
            addr_q      <= addr_d;
            owner_q     <= owner_d;
            tx_cred_q   <= tx_cred_d;
            rx_owe_q    <= rx_owe_d;
            tx_req_q    <= tx_req_d;
            v_tx_req_q  <= v_tx_req_d;
            pre_rx_q    <= pre_rx_d;
            done_q      <= done_d;
            done_data_q <= done_data_d;
            n_out_q     <= n_out_d;
            err_q       <= err_d;
        end
    end

    assign work_rdy    = ~pending_q;
    assign tx_req      = tx_req_q;
    assign v_tx_req    = v_tx_req_q;
    assign pre_rx_data = pre_rx_q;
    assign done        = done_q;
    assign done_data   = done_data_q;
    assign n_out       = n_out_q;
    assign err         = err_q;

endmodule

// File: tb/tb_rn_mc.sv
// Directed bench for rn_mc: reset, starvation, fairness,
// table full, single request and bad-id responses.
module tb_rn_mc;
    import node_package::*;

    logic         clk;
    logic         reset;
    logic [3:0]   work;
    logic [31:0]  work_addr;
    logic [3:0]   work_rdy;
    logic         pre_tx_req;
    ReqType       tx_req;
    logic         v_tx_req;
    logic         pre_rx_data;
    DataType      rx_data;
    logic         v_rx_data;
    logic [3:0]   done;
    logic [7:0]   done_data;
    logic [2:0]   n_out;
    logic         err;

    int n_pass = 0;
    int n_chk  = 0;

    rn_mc dut (
        .clk         (clk),
        .reset       (reset),
        .work        (work),
        .work_addr   (work_addr),
        .work_rdy    (work_rdy),
        .pre_tx_req  (pre_tx_req),
        .tx_req      (tx_req),
        .v_tx_req    (v_tx_req),
        .pre_rx_data (pre_rx_data),
        .rx_data     (rx_data),
        .v_rx_data   (v_rx_data),
        .done        (done),
        .done_data   (done_data),
        .n_out       (n_out),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic rsp(input logic [1:0] id, input logic [7:0] pl);
        rx_data   = '{txn_id: id, payload: pl};
        v_rx_data = 1'b1;
        step();
        v_rx_data = 1'b0;
    endtask

    initial begin
        reset = 1'b0; work = '0; work_addr = '0;
        pre_tx_req = 1'b0; rx_data = '0; v_rx_data = 1'b0;
        step(); step();
        chk("rst_rdy", work_rdy, 4'hF);
        chk("rst_v", v_tx_req, 0);
        chk("rst_req", tx_req, 0);
        chk("rst_prx", pre_rx_data, 0);
        chk("rst_done", done, 0);
        chk("rst_nout", n_out, 0);
        chk("rst_err", err, 0);
        reset = 1'b1;
        step(); chk("burst0", pre_rx_data, 1);
        step(); chk("burst1", pre_rx_data, 1);
        step(); chk("burst_end", pre_rx_data, 0);

        // credit starvation with three pending sources
        work_addr = 32'h23222120; work = 4'b0111;
        step(); work = '0;
        chk("starve_rdy", work_rdy, 4'b1000);
        for (int i = 0; i < 5; i++) begin
            step(); chk("starve_v", v_tx_req, 0);
        end
        chk("starve_rdy2", work_rdy, 4'b1000);
        pre_tx_req = 1'b1;
        step(); pre_tx_req = 1'b0;
        chk("cred_edge_v", v_tx_req, 0);
        step();
        chk("resume_v", v_tx_req, 1);
        chk("resume_req", tx_req, {2'd0, 2'd0, 8'h20});
        chk("resume_rdy", work_rdy, 4'b1001);
        chk("resume_nout", n_out, 1);

        // reset mid-traffic
        reset = 1'b0; #1;
        chk("mid_v", v_tx_req, 0);
        chk("mid_req", tx_req, 0);
        chk("mid_rdy", work_rdy, 4'hF);
        chk("mid_nout", n_out, 0);
        #2 reset = 1'b1;
        step(); chk("mid_burst0", pre_rx_data, 1);
        step(); chk("mid_burst1", pre_rx_data, 1);
        step(); chk("mid_burst_end", pre_rx_data, 0);

        // fairness: all four, one credit per cycle, repeat on src1
        work_addr = 32'h33323130; work = 4'hF; pre_tx_req = 1'b1;
        step(); work = '0;
        step();
        chk("rr0_v", v_tx_req, 1);
        chk("rr0", tx_req, {2'd0, 2'd0, 8'h30});
        step();
        chk("rr1", tx_req, {2'd1, 2'd1, 8'h31});
        work[1] = 1'b1; work_addr[15:8] = 8'h41;
        rx_data = '{txn_id: 2'd0, payload: 8'h50}; v_rx_data = 1'b1;
        step(); work = '0; v_rx_data = 1'b0;
        chk("rr2", tx_req, {2'd2, 2'd2, 8'h32});
        chk("rr_done", done, 4'b0001);
        chk("rr_done_data", done_data, 8'h50);
        chk("same_cyc_nout", n_out, 2);
        step();
        chk("rr3", tx_req, {2'd0, 2'd3, 8'h33});
        step();
        chk("rr_rep1", tx_req, {2'd3, 2'd1, 8'h41});
        chk("full_nout", n_out, 4);

        // table full: fifth request stalls until id2 frees
        work = 4'b0001; work_addr[7:0] = 8'h44;
        step(); work = '0;
        chk("full_v0", v_tx_req, 0);
        step(); pre_tx_req = 1'b0;
        chk("full_v1", v_tx_req, 0);
        chk("full_rdy", work_rdy, 4'b1110);
        chk("full_nout2", n_out, 4);
        rsp(2'd2, 8'h77);
        chk("free_v", v_tx_req, 0);
        chk("free_done", done, 4'b0100);
        chk("free_data", done_data, 8'h77);
        chk("free_nout", n_out, 3);
        step();
        chk("reuse_v", v_tx_req, 1);
        chk("reuse_req", tx_req, {2'd2, 2'd0, 8'h44});
        chk("reuse_nout", n_out, 4);

        // drain: id0->src3, id1->src1, id3->src1, id2->src0
        rsp(2'd0, 8'h60); chk("drain0", done, 4'b1000);
        chk("drain0_d", done_data, 8'h60);
        rsp(2'd1, 8'h61); chk("drain1", done, 4'b0010);
        rsp(2'd3, 8'h63); chk("drain3", done, 4'b0010);
        chk("drain3_d", done_data, 8'h63);
        rsp(2'd2, 8'h62); chk("drain2", done, 4'b0001);
        chk("drain_prx", pre_rx_data, 1);
        chk("drain_nout", n_out, 0);
        step(); chk("drain_idle", done, 0);

        // single request
        pre_tx_req = 1'b1; work = 4'b0001; work_addr[7:0] = 8'h10;
        step(); pre_tx_req = 1'b0; work = '0;
        chk("one_rdy", work_rdy, 4'b1110);
        chk("one_v0", v_tx_req, 0);
        step();
        chk("one_v", v_tx_req, 1);
        chk("one_req", tx_req, {2'd0, 2'd0, 8'h10});
        step();
        chk("one_v_end", v_tx_req, 0);
        rsp(2'd0, 8'hAB);
        chk("one_done", done, 4'b0001);
        chk("one_data", done_data, 8'hAB);
        chk("one_prx", pre_rx_data, 1);
        chk("one_nout", n_out, 0);
        step();
        chk("one_done_end", done, 0);
        chk("one_prx_end", pre_rx_data, 0);

        // unallocated id
        rsp(2'd3, 8'hEE);
        chk("bad_err", err, 1);
        chk("bad_done", done, 0);
        chk("bad_prx", pre_rx_data, 1);
        chk("bad_nout", n_out, 0);
        step(); step();
        chk("bad_sticky", err, 1);
        chk("bad_prx_end", pre_rx_data, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
